// File: rtl/inst_sram_like_responder.sv
// inst_sram_like_responder: SRAM-like instruction-port responder; issues accepted requests to a
// 1-cycle synchronous RAM and returns responses in order through a DEPTH-entry FIFO.
module inst_sram_like_responder #(
    parameter int DEPTH      = 4,
    parameter int RAM_AW     = 16,
    parameter int DATA_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_en,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wen,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic [31:0]       inst_sram_addr_ok_addr,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [3:0] DD = 4'(DATA_DELAY);

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;
    logic          r_inflight, r_is_write;
    logic [3:0]    r_head_cnt;
    logic [31:0]   r_last_addr;
    logic [PW:0]   w_occ;
    logic          w_accept, w_pop, w_unused;

    // Occupancy ignores a same-cycle pop so acceptance never depends on data_ok.
    assign w_occ    = r_count + {{PW{1'b0}}, r_inflight};
    assign w_accept = inst_sram_en && !reset && (w_occ < DEPTH_C);
    assign w_pop    = (r_count != '0) && (r_head_cnt == DD);
    assign w_unused = ^inst_sram_size;

    assign inst_sram_addr_ok      = w_accept;
    assign inst_sram_addr_ok_addr = w_accept ? inst_sram_addr : r_last_addr;
    assign inst_sram_data_ok      = w_pop;
    assign inst_sram_rdata        = w_pop ? r_mem[r_rptr] : '0;
    assign ram_en                 = w_accept;
    assign ram_wen                = (w_accept && inst_sram_wr) ? inst_sram_wen : '0;
    assign ram_addr               = inst_sram_addr[RAM_AW+1:2];
    assign ram_wdata              = inst_sram_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_inflight  <= 1'b0;
            r_is_write  <= 1'b0;
            r_head_cnt  <= '0;
            r_last_addr <= '0;
        end else begin
            r_inflight <= w_accept;
            r_is_write <= w_accept && inst_sram_wr;
            if (w_accept) r_last_addr <= inst_sram_addr;
            if (r_inflight) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count    <= r_count + {{PW{1'b0}}, r_inflight} - {{PW{1'b0}}, w_pop};
            r_head_cnt <= w_pop ? '0 : ((r_count != '0) && (r_head_cnt != DD)) ? r_head_cnt + 4'd1 : r_head_cnt;
        end
    end

    // Capture the RAM word the cycle after the access; writes answer with zero.
    always_ff @(posedge clk) begin
        if (r_inflight) r_mem[r_wptr] <= r_is_write ? '0 : ram_rdata;
    end
endmodule
